result_drain: RTL and testbench

Result drain unit for the systolic-array accelerator. Once a layer has been computed, it reads the output tile back out of the shared SRAM. A START pulse launches the drain, which reads ROWS consecutive 128-bit rows beginning at OADDR. The rows stream to the host over a valid/ready interface. This is the output-side counterpart of the 128-bit per-cycle input_data load path that fills activations and weights.

---
 rtl/result_drain.sv | 168 ++++++++++++++++
 tb/tb_result_drain.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Result drain: streams ROWS consecutive SRAM rows, starting at a latched base address, out
// through a valid/ready port. Reads are throttled so that at most two rows are ever buffered
// or in flight, which lets a 2-entry FIFO absorb the one-cycle SRAM read latency.
module result_drain #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned ROWS   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] OADDR,
  output logic              share_cen,
  output logic              share_ren,
  output logic [ADDR_W-1:0] share_addr,
  input  logic [DATA_W-1:0] share_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              BUSY,
  output logic              DONE
);

  // Counters must reach ROWS itself, hence ROWS + 1 codes.
  localparam int unsigned     CntW  = $clog2(ROWS + 1);
  localparam logic [CntW-1:0] RowsC = CntW'(ROWS);
  localparam logic [CntW-1:0] LastC = CntW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]   deliver_cnt_q, deliver_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       running;
  logic       pop;
  logic       push;
  logic       issue;
  logic       fifo_clear;
  logic [2:0] occupancy;
  logic [1:0] cnt_after_pop;

  // Host-facing outputs come straight from registered state.
  always_comb begin
    out_valid = (fifo_cnt_q != 2'd0);
    out_data  = head_q;
    out_last  = out_valid && (deliver_cnt_q == LastC);
    BUSY      = (state_q == StRun);
    DONE      = (state_q == StFin);
  end

  // Handshake decode and read throttle: never let buffered + in-flight rows exceed two.
  always_comb begin
    running   = (state_q == StRun);
    pop       = running && out_valid && out_ready;
    // A return only counts while running, so a read cut off by reset is dropped.
    push      = running && inflight_q;
    occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = running && (issue_cnt_q < RowsC) && (occupancy < 3'd2);
  end

  // SRAM request; the address holds its last issued value while idle.
  always_comb begin
    share_cen  = ~issue;
    share_ren  = ~issue;
    share_addr = addr_q;
    if (issue) begin
      share_addr = base_q + ADDR_W'(issue_cnt_q);
    end
    addr_d = share_addr;
  end

  // Control FSM next state plus issue/deliver bookkeeping.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    inflight_d    = inflight_q;
    fifo_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d       = StRun;
          base_d        = OADDR;
          issue_cnt_d   = '0;
          deliver_cnt_d = '0;
          inflight_d    = 1'b0;
          fifo_clear    = 1'b1;
        end
      end
      StRun: begin
        inflight_d = issue;
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CntW'(1);
        end
        if (pop) begin
          deliver_cnt_d = deliver_cnt_q + CntW'(1);
          if (deliver_cnt_q == LastC) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Two-entry FIFO: head drives the output, tail only fills when head is still occupied.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_after_pop = fifo_cnt_q - {1'b0, pop};
    fifo_cnt_d    = fifo_cnt_q;
    if (fifo_clear) begin
      fifo_cnt_d = 2'd0;
    end else begin
      if (pop && (fifo_cnt_q == 2'd2)) begin
        head_d = tail_q;
      end
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          head_d = share_rdata;
        end else begin
          tail_d = share_rdata;
        end
      end
      fifo_cnt_d = cnt_after_pop + {1'b0, push};
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= StIdle;
      base_q        <= '0;
      addr_q        <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      inflight_q    <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      addr_q        <= addr_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      inflight_q    <= inflight_d;
      fifo_cnt_q    <= fifo_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: SRAM model with one-cycle read latency, randomized host
// backpressure, and an address/row-order reference computed from the base address.
module tb_result_drain;

  localparam int DW = 128;
  localparam int AW = 13;
  localparam int NR = 16;

  logic          CLK;
  logic          RESET;
  logic          START;
  logic [AW-1:0] OADDR;
  logic          share_cen;
  logic          share_ren;
  logic [AW-1:0] share_addr;
  logic [DW-1:0] share_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          BUSY;
  logic          DONE;

  int            total;
  int            bad;
  logic [15:0]   salt;
  logic          req_v;
  logic [AW-1:0] req_a;

  result_drain #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .ROWS  (NR)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .OADDR      (OADDR),
    .share_cen  (share_cen),
    .share_ren  (share_ren),
    .share_addr (share_addr),
    .share_rdata(share_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Row stored at address a; with salt = 0, row k of a tile at 31 is {8{k}}.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [15:0] w;
    w = (16'(a) - 16'd31) ^ salt;
    return {8{w}};
  endfunction

  // SRAM model: request latched mid-cycle, data returned after the sampling edge.
  always @(negedge CLK) begin
    req_v <= ~share_cen;
    req_a <= share_addr;
  end

  always @(posedge CLK) begin
    if (req_v) share_rdata <= mem_word(req_a);
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_cen", DW'(share_cen), DW'(1));
    chk("rst_ren", DW'(share_ren), DW'(1));
    chk("rst_addr", DW'(share_addr), DW'(0));
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_data", out_data, DW'(0));
    chk("rst_last", DW'(out_last), DW'(0));
    chk("rst_busy", DW'(BUSY), DW'(0));
    chk("rst_done", DW'(DONE), DW'(0));
  endtask

  // Caller sits 1ns after an edge. mode: 0 ready high, 1 low for 10 cycles then 1010...,
  // 2 random. abort_at > 0 resets once that many beats have transferred.
  task automatic run_drain(input logic [AW-1:0] base, input int mode, input int abort_at,
                           input bit busy_start, input bit fin_start);
    int            c;
    int            issued;
    int            beats;
    int            n_done;
    int            first_issue_c;
    int            first_beat_c;
    int            done_c;
    bit            stalled;
    bit            finished;
    bit            aborted;
    logic [DW-1:0] held_data;
    logic          held_last;
    c = 0; issued = 0; beats = 0; n_done = 0;
    first_issue_c = -1; first_beat_c = -1; done_c = -1;
    stalled = 1'b0; finished = 1'b0; aborted = 1'b0;
    held_data = '0; held_last = 1'b0;
    START = 1'b1;
    OADDR = base;
    @(posedge CLK); #1;
    while (!finished) begin
      START = 1'b0;
      OADDR = AW'($urandom);
      if (busy_start && c == 5) begin
        START = 1'b1;
        OADDR = 13'd100;
      end
      if (fin_start && DONE) begin
        START = 1'b1;
        OADDR = 13'd555;
      end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (c >= 10) && (((c - 10) % 2) == 0);
      else out_ready = 1'($urandom_range(0, 1));
      #1;
      if (abort_at > 0 && beats == abort_at) begin
        #1;
        RESET = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge CLK); #1;
        chk("reset_hold_done", DW'(DONE), DW'(0));
        chk("reset_hold_cen", DW'(share_cen), DW'(1));
        RESET = 1'b0;
        aborted = 1'b1;
        finished = 1'b1;
      end else begin
        chk("ren_eq_cen", DW'(share_ren), DW'(share_cen));
        if (stalled) begin
          chk("stall_valid", DW'(out_valid), DW'(1));
          chk("stall_data", out_data, held_data);
          chk("stall_last", DW'(out_last), DW'(held_last));
        end
        if (mode == 0 && c == 1) chk("valid_before_e2", DW'(out_valid), DW'(0));
        if (!share_cen) begin
          if (first_issue_c < 0) first_issue_c = c;
          chk("issue_addr", DW'(share_addr), DW'((int'(base) + issued) % 8192));
          issued++;
        end
        if (out_valid) begin
          chk("last_flag", DW'(out_last), DW'(beats == NR - 1));
          if (out_ready) begin
            if (first_beat_c < 0) first_beat_c = c;
            chk("beat_data", out_data, mem_word(AW'((int'(base) + beats) % 8192)));
            beats++;
          end
        end
        stalled   = out_valid && !out_ready;
        held_data = out_data;
        held_last = out_last;
        chk("occupancy", DW'((issued - beats) <= 2), DW'(1));
        if (mode == 1 && c == 9) chk("bp_two_reads", DW'(issued), DW'(2));
        if (DONE) begin
          n_done++;
          done_c = c;
          chk("done_after_all", DW'(beats), DW'(NR));
          chk("busy_in_done", DW'(BUSY), DW'(0));
        end else begin
          chk("busy_in_run", DW'(BUSY), DW'(1));
        end
        @(posedge CLK); #1;
        c++;
        if (done_c >= 0) begin
          chk("idle_busy", DW'(BUSY), DW'(0));
          chk("idle_done", DW'(DONE), DW'(0));
          chk("idle_cen", DW'(share_cen), DW'(1));
          finished = 1'b1;
        end else if (c > 200) begin
          chk("timeout", DW'(0), DW'(1));
          finished = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    if (!aborted) begin
      chk("n_issued", DW'(issued), DW'(NR));
      chk("n_beats", DW'(beats), DW'(NR));
      chk("n_done", DW'(n_done), DW'(1));
      if (mode == 0) begin
        chk("first_issue_cycle", DW'(first_issue_c), DW'(0));
        chk("first_beat_cycle", DW'(first_beat_c), DW'(2));
        chk("done_cycle", DW'(done_c), DW'(NR + 2));
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    salt = 16'd0;
    RESET = 1'b0;
    START = 1'b0;
    OADDR = '0;
    out_ready = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle_after_reset_busy", DW'(BUSY), DW'(0));
    chk("idle_after_reset_cen", DW'(share_cen), DW'(1));
    // Full drain at 31; START in the FIN cycle must be ignored.
    run_drain(13'd31, 0, 0, 1'b0, 1'b1);
    // Launched in the cycle right after FIN; address wraps past 8191.
    salt = 16'($urandom);
    run_drain(13'd8190, 2, 0, 1'b0, 1'b0);
    run_drain(13'd500, 1, 0, 1'b0, 1'b0);
    run_drain(13'd31, 0, 0, 1'b1, 1'b0);
    run_drain(13'd40, 0, 5, 1'b0, 1'b0);
    run_drain(13'd200, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      salt = 16'($urandom);
      run_drain(AW'($urandom), 2, 0, 1'b0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
